// File: rtl/alu_issue_stage.sv
// Operand fetch, issue and writeback around the registered 19-bit ALU.
// Owns a small register file; one instruction per valid/ready handshake.
module alu_issue_stage #(
  parameter int REG_ADDR_W = 2,
  parameter int DATA_W     = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [16:0]           instr_in,
  output logic [18:0]           alu_inst,
  input  logic [15:0]           alu_r,
  output logic                  done,
  output logic                  carry,
  output logic                  err,
  input  logic [REG_ADDR_W-1:0] dbg_addr,
  output logic [DATA_W-1:0]     dbg_data
);

  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_LDI = 3'b101;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    WB   = 2'd2
  } state_t;

  state_t state;
  state_t state_n;

  logic [DATA_W-1:0]     rf [NUM_REGS];
  logic [2:0]            op_q;
  logic [REG_ADDR_W-1:0] rd_q;
  logic [REG_ADDR_W-1:0] rd_nx;

  logic [2:0]            op;
  logic [REG_ADDR_W-1:0] rd;
  logic [REG_ADDR_W-1:0] rs1;
  logic [REG_ADDR_W-1:0] rs2;
  logic [DATA_W-1:0]     imm;

  logic accept;
  logic is_alu;
  logic is_ldi;
  logic is_ill;

  assign op     = instr_in[16:14];
  assign rd     = instr_in[13:12];
  assign rs1    = instr_in[11:10];
  assign rs2    = instr_in[9:8];
  assign imm    = instr_in[7:0];

  assign in_ready = (state == IDLE);
  assign accept   = in_valid && in_ready;
  assign is_alu   = (op <= OP_OR);
  assign is_ldi   = (op == OP_LDI);
  assign is_ill   = (op > OP_LDI);

  // MUL high byte goes to the next register, wrapping past the top
  assign rd_nx    = rd_q + 1'b1;
  assign dbg_data = rf[dbg_addr];

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE:    if (accept && is_alu) state_n = EXEC;
      EXEC:    state_n = WB;
      WB:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      alu_inst <= '0;
      op_q     <= '0;
      rd_q     <= '0;
      carry    <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (1'b1)
        accept && is_alu: begin
          alu_inst <= {op, rf[rs1], rf[rs2]};
          op_q     <= op;
          rd_q     <= rd;
        end
        accept && is_ldi: begin
          rf[rd] <= imm;
          done   <= 1'b1;
        end
        accept && is_ill: begin
          err <= 1'b1;
        end
        state == WB: begin
          rf[rd_q] <= alu_r[7:0];
          if (op_q == OP_MUL) rf[rd_nx] <= alu_r[15:8];
          if (op_q == OP_ADD) carry <= alu_r[8];
          done <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed plus randomized bench for alu_issue_stage with an ALU model
// and a register-file reference model.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [16:0] instr_in;
  logic [18:0] alu_inst;
  logic [15:0] alu_r = '0;
  logic        done;
  logic        carry;
  logic        err;
  logic [1:0]  dbg_addr;
  logic [7:0]  dbg_data;

  int n_cmp = 0;
  int n_bad = 0;

  logic [7:0] m_rf [4];
  logic       m_carry;

  alu_issue_stage dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .instr_in (instr_in),
    .alu_inst (alu_inst),
    .alu_r    (alu_r),
    .done     (done),
    .carry    (carry),
    .err      (err),
    .dbg_addr (dbg_addr),
    .dbg_data (dbg_data)
  );

  always #10 clk = ~clk;

  // Registered ALU: junk upper bytes where the stage must ignore them
  always @(posedge clk) begin
    case (alu_inst[18:16])
      3'd0: alu_r <= {7'd0, 9'(alu_inst[15:8]) + 9'(alu_inst[7:0])};
      3'd1: alu_r <= {8'hA5, alu_inst[15:8] - alu_inst[7:0]};
      3'd2: alu_r <= alu_inst[15:8] * alu_inst[7:0];
      3'd3: alu_r <= {alu_r[15:8] ^ 8'h5A, alu_inst[15:8] & alu_inst[7:0]};
      3'd4: alu_r <= {alu_r[15:8] ^ 8'hC3, alu_inst[15:8] | alu_inst[7:0]};
      default: alu_r <= 16'hDEAD;
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_state(input string tag);
    for (int i = 0; i < 4; i++) begin
      dbg_addr = 2'(i);
      #1;
      chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(m_rf[i]));
    end
    chk({tag, "_carry"}, 32'(carry), 32'(m_carry));
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) m_rf[i] = 8'h00;
    m_carry = 1'b0;
  endtask

  // Called at a negedge; returns at a negedge with the stage IDLE
  task automatic issue(input logic [2:0] op, input logic [1:0] rd,
                       input logic [1:0] rs1, input logic [1:0] rs2,
                       input logic [7:0] imm, input bit hold,
                       input logic [16:0] nxt);
    logic [7:0] a, b;
    logic [15:0] p;
    logic [8:0] s;
    int n;
    instr_in = {op, rd, rs1, rs2, imm};
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("accept_wait", 32'(n < 10), 32'd1);
    a = m_rf[rs1];
    b = m_rf[rs2];
    @(negedge clk);
    in_valid = 1'b0;
    if (op == 3'b101) begin
      m_rf[rd] = imm;
      chk("ldi_done", 32'(done), 32'd1);
      chk("ldi_ready", 32'(in_ready), 32'd1);
    end else if (op > 3'b101) begin
      chk("ill_err", 32'(err), 32'd1);
      chk("ill_done", 32'(done), 32'd0);
      chk("ill_ready", 32'(in_ready), 32'd1);
    end else begin
      chk("alu_inst", 32'(alu_inst), 32'({op, a, b}));
      chk("exec_ready", 32'(in_ready), 32'd0);
      chk("exec_done", 32'(done), 32'd0);
      if (hold) begin
        instr_in = nxt;
        in_valid = 1'b1;
      end
      @(negedge clk);
      chk("wb_ready", 32'(in_ready), 32'd0);
      chk("wb_done", 32'(done), 32'd0);
      @(negedge clk);
      chk("ret_done", 32'(done), 32'd1);
      chk("ret_ready", 32'(in_ready), 32'd1);
      case (op)
        3'd0: begin
          s = {1'b0, a} + {1'b0, b};
          m_rf[rd] = s[7:0];
          m_carry = s[8];
        end
        3'd1: m_rf[rd] = a - b;
        3'd2: begin
          p = a * b;
          m_rf[rd] = p[7:0];
          m_rf[(rd + 1) % 4] = p[15:8];
        end
        3'd3: m_rf[rd] = a & b;
        default: m_rf[rd] = a | b;
      endcase
    end
    chk_state("post");
  endtask

  initial begin
    rst      = 1'b1;
    in_valid = 1'b0;
    instr_in = '0;
    dbg_addr = '0;
    model_reset();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk("rst_ready", 32'(in_ready), 32'd1);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_alu_inst", 32'(alu_inst), 32'd0);
    chk_state("rst");

    // Back-to-back LDIs, one per cycle
    issue(3'b101, 2'd0, 2'd0, 2'd0, 8'hC8, 1'b0, '0);
    issue(3'b101, 2'd1, 2'd0, 2'd0, 8'h64, 1'b0, '0);
    dbg_addr = 2'd0; #1;
    chk("ldi_r0_const", 32'(dbg_data), 32'hC8);

    issue(3'b000, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, '0);
    chk("add_alu_inst_const", 32'(alu_inst), 32'h0C864);
    dbg_addr = 2'd2; #1;
    chk("add_r2_const", 32'(dbg_data), 32'h2C);
    chk("add_carry_const", 32'(carry), 32'd1);

    issue(3'b010, 2'd3, 2'd0, 2'd1, 8'h00, 1'b0, '0);
    dbg_addr = 2'd0; #1;
    chk("mul_wrap_r0_const", 32'(dbg_data), 32'h4E);
    dbg_addr = 2'd3; #1;
    chk("mul_r3_const", 32'(dbg_data), 32'h20);

    issue(3'b001, 2'd1, 2'd1, 2'd0, 8'h00, 1'b0, '0);
    issue(3'b101, 2'd0, 2'd0, 2'd0, 8'h0F, 1'b0, '0);
    issue(3'b101, 2'd1, 2'd0, 2'd0, 8'h3C, 1'b0, '0);
    issue(3'b011, 2'd2, 2'd0, 2'd1, 8'h00, 1'b0, '0);
    dbg_addr = 2'd2; #1;
    chk("and_r2_const", 32'(dbg_data), 32'h0C);

    issue(3'b110, 2'd2, 2'd0, 2'd1, 8'hFF, 1'b0, '0);
    issue(3'b111, 2'd3, 2'd0, 2'd1, 8'hFF, 1'b0, '0);

    // Held in_valid during EXEC/WB must wait for IDLE
    issue(3'b100, 2'd3, 2'd0, 2'd1, 8'h00, 1'b1,
          {3'b101, 2'd3, 2'd0, 2'd0, 8'h99});
    issue(3'b101, 2'd3, 2'd0, 2'd0, 8'h99, 1'b0, '0);

    // Reset during EXEC aborts the ADD
    instr_in = {3'b000, 2'd2, 2'd0, 2'd1, 8'h00};
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    chk("abort_ready", 32'(in_ready), 32'd1);
    chk("abort_done", 32'(done), 32'd0);
    chk_state("abort");
    repeat (2) @(negedge clk);
    chk("abort_late_done", 32'(done), 32'd0);
    chk_state("abort_late");

    // Reset wins over a simultaneous accept
    instr_in = {3'b101, 2'd1, 2'd0, 2'd0, 8'h77};
    in_valid = 1'b1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b0;
    chk("rstpri_done", 32'(done), 32'd0);
    chk_state("rstpri");

    for (int k = 0; k < 40; k++) begin
      issue(3'($urandom_range(0, 7)), 2'($urandom_range(0, 3)),
            2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
            8'($urandom), 1'b0, '0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
